bargraph_ctrl: RTL

BARGRAPH_CTRL -- requirements
Module: bargraph_ctrl

---
 rtl/bargraph_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bargraph_ctrl.sv
// Bar-graph drive controller: power-up self-test sweep, slew-limited tracking of the
// latest measurement, and a peak-hold output with linear decay.
`timescale 1ns/1ps

module bargraph_ctrl #(
    parameter int TICK_DIV   = 50000,
    parameter int SLEW_STEP  = 8,
    parameter int SWEEP_STEP = 4,
    parameter int HOLD_TICKS = 500,
    parameter int MAX_VALUE  = 300
) (
    input  logic       i_clock_50,
    input  logic       i_reset,
    input  logic [8:0] i_measure,
    input  logic       i_measure_valid,
    input  logic       i_test_mode,
    output logic [8:0] o_signal,
    output logic [8:0] o_peak,
    output logic       o_update,
    output logic       o_busy
);

    localparam int AW     = 11;
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [AW-1:0]     MAX_A   = AW'(MAX_VALUE);
    localparam logic [AW-1:0]     SLEW_A  = AW'(SLEW_STEP);
    localparam logic [AW-1:0]     SWEEP_A = AW'(SWEEP_STEP);
    localparam logic [DIV_W-1:0]  DIV_END = DIV_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_N  = HOLD_W'(HOLD_TICKS);

    typedef enum logic [1:0] {SWEEP_UP, SWEEP_DOWN, RUN} state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [HOLD_W-1:0] r_hold;
    logic [8:0]        r_target;
    logic [8:0]        r_signal;
    logic [8:0]        r_peak;
    logic              r_update;
    logic              r_busy;

    logic              w_tick;
    logic [AW-1:0]     w_sig;
    logic [AW-1:0]     w_tgt;
    logic [AW-1:0]     w_meas;
    logic [AW-1:0]     w_up;
    logic [AW-1:0]     w_sweep_up;
    logic [AW-1:0]     w_sweep_dn;
    logic [AW-1:0]     w_diff;
    logic [AW-1:0]     w_step;
    logic [AW-1:0]     w_slew;
    logic [AW-1:0]     w_next_sig;
    state_t            w_next_state;

    assign w_tick = (r_div == DIV_END);
    assign w_sig  = {2'b00, r_signal};
    assign w_tgt  = {2'b00, r_target};
    assign w_meas = {2'b00, i_measure};

    // Widened arithmetic keeps sums and differences from wrapping before clamping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_up       = w_sig + SWEEP_A;
        w_sweep_up = (w_up > MAX_A) ? MAX_A : w_up;
        w_sweep_dn = (w_sig > SWEEP_A) ? (w_sig - SWEEP_A) : '0;
        w_diff     = (w_tgt > w_sig) ? (w_tgt - w_sig) : (w_sig - w_tgt);
        w_step     = (w_diff > SLEW_A) ? SLEW_A : w_diff;
        w_slew     = (w_tgt > w_sig) ? (w_sig + w_step) : (w_sig - w_step);

        w_next_state = r_state;
        w_next_sig   = w_sig;
        case (r_state)
            SWEEP_UP: begin
                if (w_tick) begin
                    w_next_sig = w_sweep_up;
                    if (w_sweep_up == MAX_A) w_next_state = SWEEP_DOWN;
                end
            end
            SWEEP_DOWN: begin
                if (w_tick) begin
                    w_next_sig = w_sweep_dn;
                    if (w_sweep_dn == '0) w_next_state = RUN;
                end
            end
            RUN: begin
                if (i_test_mode)  w_next_state = SWEEP_UP;
                else if (w_tick)  w_next_sig   = w_slew;
            end
            default: w_next_state = SWEEP_UP;
        endcase
    end

    always_ff @(posedge i_clock_50) begin
        if (i_reset) begin
            r_state  <= SWEEP_UP;
            r_div    <= '0;
            r_hold   <= '0;
            r_target <= '0;
            r_signal <= '0;
            r_peak   <= '0;
            r_update <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
            if (i_measure_valid)
                r_target <= (w_meas > MAX_A) ? MAX_A[8:0] : i_measure;
            r_state  <= w_next_state;
            r_signal <= w_next_sig[8:0];
            r_update <= (w_next_sig[8:0] != r_signal);
            r_busy   <= (w_next_state != RUN);

            // Peak is forced to zero for the whole sweep, including the edge that starts it.
            if (w_next_state != RUN) begin
                r_peak <= '0;
                r_hold <= '0;
            end else if (r_state == RUN && w_tick) begin
                if (w_next_sig >= {2'b00, r_peak}) begin
                    r_peak <= w_next_sig[8:0];
                    r_hold <= HOLD_N;
                end else if (r_hold != '0) begin
                    r_hold <= r_hold - HOLD_W'(1);
                end else begin
                    r_peak <= r_peak - 9'd1;
                end
            end
        end
    end

    assign o_signal = r_signal;
    assign o_peak   = r_peak;
    assign o_update = r_update;
    assign o_busy   = r_busy;

endmodule
